// File: rtl/rr_resource_arbiter_if.sv
// rr_resource_arbiter_if
//   Bundles the request/grant signals between the requesting FSMs and the
//   shared-resource arbiter.
//
//   Handshake: req[i] is a level request. A requester raises it and keeps it
//   high for as long as it wants or uses the resource. gnt[i] high means
//   requester i owns the resource in this cycle. Ownership ends when the
//   requester drops req[i] or when the arbiter revokes gnt[i] on timeout.
//   A requester must never use the resource while its gnt bit is low.
//
//   Signals:
//     req          requester -> arbiter, N-bit level request
//     gnt          arbiter -> requester, N-bit one-hot grant (zero when no owner)
//     gnt_id       arbiter -> requester, index of the current owner
//     busy         arbiter -> requester, high while a grant is held
//     timeout_err  arbiter -> requester, one-cycle pulse on a timeout revoke
//     state        arbiter -> observer, controller state (IDLE/HOLD/GAP)
//   Modports: master = requester side, slave = arbiter side.
interface rr_resource_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_err;
    logic [1:0]     state;

    modport master (
        output req,
        input  gnt, gnt_id, busy, timeout_err, state
    );

    modport slave (
        input  req,
        output gnt, gnt_id, busy, timeout_err, state
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter
//   Round-robin arbiter with hold timeout that shares one downstream
//   resource among N requesters. A grant is held until the owner drops its
//   request, or revoked after TIMEOUT cycles (TIMEOUT=0 disables the limit).
//   Every grant is followed by a one-cycle GAP so the resource can turn
//   around. A requester that timed out is locked out until it drops req.
//
//   Ports:
//     clk      single clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      rr_resource_arbiter_if.slave (req in; gnt, gnt_id, busy,
//              timeout_err, state out)
module rr_resource_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    rr_resource_arbiter_if.slave    bus
);
    // A zero-width counter is not legal, so keep one bit when timeout is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   gnt_q, gnt_n;
    logic [IDW-1:0] gnt_id_q, gnt_id_n;
    logic [IDW-1:0] ptr_q, ptr_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic [N-1:0]   lock_q, lock_n;
    logic           terr_q, terr_n;
    logic           busy;

    logic [N-1:0]   elig;
    logic [IDW-1:0] win;
    logic           win_vld;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    assign elig = bus.req & ~lock_q;

    // Rotating first-set-bit search starting at ptr_q.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (sum >= (IDW + 1)'(N)) begin
                sum = sum - (IDW + 1)'(N);
            end
            idx = sum[IDW-1:0];
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    // State register (all controller state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            lock_q   <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            gnt_q    <= gnt_n;
            gnt_id_q <= gnt_id_n;
            ptr_q    <= ptr_n;
            cnt_q    <= cnt_n;
            lock_q   <= lock_n;
            terr_q   <= terr_n;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_n  = state_q;
        gnt_n    = gnt_q;
        gnt_id_n = gnt_id_q;
        ptr_n    = ptr_q;
        cnt_n    = cnt_q;
        terr_n   = 1'b0;
        // Any requester sampled low loses its lockout.
        lock_n   = lock_q & bus.req;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_n       = HOLD;
                    gnt_n         = '0;
                    gnt_n[win]    = 1'b1;
                    gnt_id_n      = win;
                    ptr_n         = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
                    cnt_n         = '0;
                end
            end
            HOLD: begin
                // Release wins over a timeout landing on the same edge.
                if (!bus.req[gnt_id_q]) begin
                    state_n = GAP;
                    gnt_n   = '0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    state_n          = GAP;
                    gnt_n            = '0;
                    terr_n           = 1'b1;
                    lock_n[gnt_id_q] = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy = (state_q == HOLD);
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.busy        = busy;
    assign bus.timeout_err = terr_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter
//   Directed bench for rr_resource_arbiter (N=4, TIMEOUT=16). Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
module tb_rr_resource_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    rr_resource_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    rr_resource_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic [3:0] g,
                             input logic b, input logic te);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
        check({tag, ".terr"}, 32'(bus.timeout_err), 32'(te));
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.req     = '0;

        // 1. Reset.
        tick();
        tick();
        check_out("rst_hold", 2'b00, 4'b0000, 1'b0, 1'b0);
        check("rst_hold.id", 32'(bus.gnt_id), 32'd0);
        reset_n = 1'b1;
        tick();
        check_out("rst_rel", 2'b00, 4'b0000, 1'b0, 1'b0);

        // 2. Single requester, 5 cycles of ownership.
        bus.req = 4'b0010;
        tick();
        check_out("single.grant", 2'b01, 4'b0010, 1'b1, 1'b0);
        check("single.id", 32'(bus.gnt_id), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("single.hold", 2'b01, 4'b0010, 1'b1, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check_out("single.gap", 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("single.idle", 2'b00, 4'b0000, 1'b0, 1'b0);

        // 1b. Asynchronous reset in HOLD (ptr is 2 here, grant goes to 0).
        bus.req = 4'b0001;
        tick();
        check_out("arst.pre", 2'b01, 4'b0001, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_out("arst.async", 2'b00, 4'b0000, 1'b0, 1'b0);
        check("arst.id", 32'(bus.gnt_id), 32'd0);
        #1;
        reset_n = 1'b1;
        bus.req = 4'b1111;

        // 3. Round robin from ptr=0: order 0,1,2,3,0 with 2 dead cycles.
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("rr.grant", 2'b01, 4'(1 << order[k]), 1'b1, 1'b0);
            check("rr.id", 32'(bus.gnt_id), 32'(order[k]));
            tick();
            check_out("rr.hold", 2'b01, 4'(1 << order[k]), 1'b1, 1'b0);
            bus.req[order[k]] = 1'b0;
            tick();
            check_out("rr.gap", 2'b10, 4'b0000, 1'b0, 1'b0);
            bus.req[order[k]] = 1'b1;
            tick();
            check_out("rr.idle", 2'b00, 4'b0000, 1'b0, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check_out("rr.quiet", 2'b00, 4'b0000, 1'b0, 1'b0);

        // 4. Timeout on requester 2 (ptr=1, search 1,2).
        bus.req = 4'b0100;
        tick();
        check_out("to.grant", 2'b01, 4'b0100, 1'b1, 1'b0);
        check("to.id", 32'(bus.gnt_id), 32'd2);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check_out("to.hold", 2'b01, 4'b0100, 1'b1, 1'b0);
        end
        tick();
        check_out("to.gap", 2'b10, 4'b0000, 1'b0, 1'b1);
        tick();
        check_out("to.idle", 2'b00, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("to.locked", 2'b00, 4'b0000, 1'b0, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check_out("to.drop", 2'b00, 4'b0000, 1'b0, 1'b0);
        bus.req = 4'b0100;
        tick();
        check_out("to.regrant", 2'b01, 4'b0100, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_out("to.rel", 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();

        // 5. Release on the limit edge (ptr=3, search 3,0 -> 0).
        bus.req = 4'b0001;
        tick();
        check_out("lim.grant", 2'b01, 4'b0001, 1'b1, 1'b0);
        check("lim.id", 32'(bus.gnt_id), 32'd0);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check_out("lim.hold", 2'b01, 4'b0001, 1'b1, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check_out("lim.gap", 2'b10, 4'b0000, 1'b0, 1'b0);
        // Re-raise in GAP: requester 0 must not be locked.
        bus.req = 4'b0001;
        tick();
        check_out("lim.idle", 2'b00, 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("lim.nolock", 2'b01, 4'b0001, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        tick();

        // 6. Lockout of 0 does not starve 1 (ptr=1).
        bus.req = 4'b0011;
        tick();
        check("ls.first", 32'(bus.gnt_id), 32'd1);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0011;
        tick();
        tick();
        check_out("ls.own0", 2'b01, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
        end
        check_out("ls.last", 2'b01, 4'b0001, 1'b1, 1'b0);
        tick();
        check_out("ls.to", 2'b10, 4'b0000, 1'b0, 1'b1);
        tick();
        for (int r = 0; r < 2; r++) begin
            tick();
            check_out("ls.only1", 2'b01, 4'b0010, 1'b1, 1'b0);
            check("ls.only1.id", 32'(bus.gnt_id), 32'd1);
            bus.req = 4'b0001;
            tick();
            bus.req = 4'b0011;
            tick();
        end
        // Drop both; requester 0 becomes eligible again (ptr=2 -> 0 first).
        bus.req = 4'b0000;
        tick();
        check_out("ls.drop", 2'b00, 4'b0000, 1'b0, 1'b0);
        bus.req = 4'b0011;
        tick();
        check_out("ls.back0", 2'b01, 4'b0001, 1'b1, 1'b0);
        check("ls.back0.id", 32'(bus.gnt_id), 32'd0);
        bus.req = 4'b0000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
